// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer and its sub-blocks.
// State encoding is fixed so that bit 0 marks the qualifying (WAIT_*) states.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam int STABLE_CYCLES_DEFAULT = 16;

  function automatic logic is_wait_state(input state_t st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync.sv
// Two-flop synchronizer for one asynchronous input; 2-cycle latency, no backpressure.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounced level plus one-cycle rise/fall pulses from a raw button input.
// Latency STABLE_CYCLES+3 edges from a stable input change; no backpressure (free-running).
module btn_debounce_pulse
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );

  // The sample that opens a WAIT state counts as the first; cnt tracks the ones after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE_HIGH;
            busy      <= 1'b0;
            btn_level <= 1'b1;
            btn_rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= IDLE_HIGH;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE_LOW;
            busy      <= 1'b0;
            btn_level <= 1'b0;
            btn_fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          // Corrupted encoding: fall back to the reset posture.
          state     <= IDLE_LOW;
          cnt       <= '0;
          btn_level <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench: a run-length reference model predicts outputs per edge; a monitor compares.
module tb_btn_debounce_pulse;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_rise, btn_fall, busy;

  btn_debounce_pulse #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Expected {level, rise, fall, busy} after each edge.
  logic [3:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: input seen two edges late; a new level is accepted once
  // S+1 consecutive samples disagree with the current level.
  int m_d1 = 0, m_d2 = 0, m_lvl = 0, m_run = 0;
  always @(posedge clk) begin
    int samp;
    logic r, f;
    r = 1'b0;
    f = 1'b0;
    if (rst) begin
      m_d1 = 0; m_d2 = 0; m_lvl = 0; m_run = 0;
    end else begin
      samp = m_d2;
      if (samp != m_lvl) begin
        m_run++;
        if (m_run == S + 1) begin
          m_lvl = samp;
          m_run = 0;
          r = (m_lvl == 1);
          f = (m_lvl == 0);
        end
      end else begin
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = int'(btn_in);
    end
    exp_q.push_back({m_lvl[0], r, f, (m_run != 0)});
  end

  // Monitor: count observed pulses and feed a 4-bit counter model from btn_rise.
  logic phase6 = 1'b0;
  int   rises6 = 0, falls6 = 0;
  logic [3:0] ctr4 = 4'd0;
  always @(negedge clk) begin
    logic [3:0] got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {btn_level, btn_rise, btn_fall, busy};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL outputs t=%0t {level,rise,fall,busy} got=%b exp=%b", $time, got, exp);
      end
      if (phase6) begin
        if (btn_rise === 1'b1) begin
          rises6++;
          ctr4 = ctr4 + 4'd1;
        end
        if (btn_fall === 1'b1) falls6++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    int bounce[6];
    bounce = '{1, 0, 1, 1, 0, 1};

    // 1: reset then idle low
    rst = 1'b1; btn_in = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(10);

    // 2: clean press held
    btn_in = 1'b1;
    cyc(12);

    // 3: short low glitch while high
    btn_in = 1'b0;
    cyc(3);
    btn_in = 1'b1;
    cyc(10);

    // 4: release, then bounce train into a held press
    btn_in = 1'b0;
    cyc(12);
    foreach (bounce[i]) begin
      btn_in = bounce[i][0];
      cyc(1);
    end
    cyc(12);

    // 5: reset mid-qualification with the button still held
    btn_in = 1'b0;
    cyc(12);
    btn_in = 1'b1;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(12);

    // 6: five clean press/release cycles counted by a 4-bit counter
    btn_in = 1'b0;
    cyc(20);
    phase6 = 1'b1;
    for (int p = 0; p < 5; p++) begin
      btn_in = 1'b1;
      cyc(20);
      btn_in = 1'b0;
      cyc(20);
    end
    phase6 = 1'b0;
    check_int("rise_count", rises6, 5);
    check_int("fall_count", falls6, 5);
    check_int("counter4", int'(ctr4), 5);

    // Random runs of varying length, with occasional reset pulses
    for (int k = 0; k < 80; k++) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(1, 2 * S + 3));
    end

    cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
